jedro_1_mem_arbiter: RTL and testbench

//  Shares one bytewrite SRAM port between jedro_1 instruction and data interfaces.

---
 rtl/jedro_1_pkg.sv | 24 ++
 rtl/jedro_1_rr_arb2.sv | 41 ++++
 rtl/jedro_1_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_jedro_1_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jedro_1_pkg.sv
//==============================================================================
// Module   : jedro_1_pkg
// Brief    : Shared types for the jedro_1 instruction/data memory arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package jedro_1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DATA  = 2'd2
    } arb_owner_e;

endpackage

`default_nettype wire

// File: rtl/jedro_1_rr_arb2.sv
//==============================================================================
// Module   : jedro_1_rr_arb2
// Brief    : Two-way round-robin picker (instr vs data) with last-grant register.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module jedro_1_rr_arb2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_instr_i,
    input  logic req_data_i,
    input  logic accept_i,
    output logic gnt_instr_o,
    output logic gnt_data_o
);

    // 1 when data held the last grant; reset favours instr on the first tie.
    logic last_data_q;
    logic last_data_d;

    always_comb begin
        gnt_instr_o = req_instr_i & (~req_data_i | last_data_q);
        gnt_data_o  = req_data_i  & (~req_instr_i | ~last_data_q);
        last_data_d = last_data_q;
        if (accept_i && (gnt_instr_o || gnt_data_o)) begin
            last_data_d = gnt_data_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_data_q <= 1'b1;
        end else begin
            last_data_q <= last_data_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/jedro_1_mem_arbiter.sv
//==============================================================================
// Module   : jedro_1_mem_arbiter
// Brief    : Shares one bytewrite SRAM port between jedro_1 instr and data buses.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module jedro_1_mem_arbiter
    import jedro_1_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    instr_req_i,
    input  logic [DATA_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    output logic                    instr_err_o,
    input  logic                    data_req_i,
    input  logic [DATA_WIDTH/8-1:0] data_we_i,
    input  logic [DATA_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_rvalid_o,
    output logic                    data_wvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    data_err_o,
    output logic                    mem_req_o,
    output logic [DATA_WIDTH/8-1:0] mem_we_o,
    output logic [DATA_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_rvalid_i,
    input  logic                    mem_wvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    mem_err_i
);

    localparam int             TMO_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    arb_state_e               state_q, state_d;
    arb_owner_e               owner_q, owner_d;
    logic [TMO_W-1:0]         tmo_cnt_q, tmo_cnt_d;
    logic                     mem_req_q, mem_req_d;
    logic [DATA_WIDTH/8-1:0]  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;

    logic w_gnt_instr, w_gnt_data;
    logic w_in_wait, w_rsp, w_tmo, w_own_instr, w_own_data;

    jedro_1_rr_arb2 u_rr_arb2 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_instr_i (instr_req_i),
        .req_data_i  (data_req_i),
        .accept_i    (state_q == ST_IDLE),
        .gnt_instr_o (w_gnt_instr),
        .gnt_data_o  (w_gnt_data)
    );

    assign w_in_wait   = (state_q == ST_WAIT);
    assign w_rsp       = mem_rvalid_i | mem_wvalid_i | mem_err_i;
    assign w_tmo       = w_in_wait & (tmo_cnt_q == C_TMO_LAST);
    assign w_own_instr = w_in_wait & (owner_q == OWN_INSTR);
    assign w_own_data  = w_in_wait & (owner_q == OWN_DATA);

    // Responses reach only the owner, and only while a transaction is waiting.
    always_comb begin
        instr_rvalid_o = w_own_instr & mem_rvalid_i;
        instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
        instr_err_o    = w_own_instr & (mem_err_i | w_tmo);
        data_rvalid_o  = w_own_data & mem_rvalid_i;
        data_wvalid_o  = w_own_data & mem_wvalid_i;
        data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
        data_err_o     = w_own_data & (mem_err_i | w_tmo);
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        tmo_cnt_d   = tmo_cnt_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (w_gnt_data) begin
                    state_d     = ST_ISSUE;
                    owner_d     = OWN_DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = data_we_i;
                    mem_addr_d  = data_addr_i;
                    mem_wdata_d = data_wdata_i;
                end else if (w_gnt_instr) begin
                    state_d     = ST_ISSUE;
                    owner_d     = OWN_INSTR;
                    mem_req_d   = 1'b1;
                    mem_we_d    = '0;
                    mem_addr_d  = instr_addr_i;
                    mem_wdata_d = '0;
                end
            end
            ST_ISSUE: begin
                state_d   = ST_WAIT;
                tmo_cnt_d = '0;
            end
            ST_WAIT: begin
                if (w_rsp || w_tmo) begin
                    state_d   = ST_IDLE;
                    owner_d   = OWN_NONE;
                    tmo_cnt_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            tmo_cnt_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            tmo_cnt_q   <= tmo_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_jedro_1_mem_arbiter.sv
//==============================================================================
// Module   : tb_jedro_1_mem_arbiter
// Brief    : Directed scoreboard bench for jedro_1_mem_arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_jedro_1_mem_arbiter;

    typedef struct packed {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mexp_t;

    typedef struct packed {
        logic        rv;
        logic        wv;
        logic        er;
        logic [31:0] rd;
    } drv_t;

    typedef struct packed {
        logic        ir;
        logic [31:0] ird;
        logic        ie;
        logic        dr;
        logic        dw;
        logic [31:0] drd;
        logic        de;
    } rexp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        data_req_i;
    logic [3:0]  data_we_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic        data_wvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        mem_req_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic        mem_wvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;

    int n_chk = 0;
    int n_err = 0;

    mexp_t mq[$];
    drv_t  dq[$];
    rexp_t rq[$];

    jedro_1_mem_arbiter #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_rvalid_o  (data_rvalid_o),
        .data_wvalid_o  (data_wvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_wvalid_i   (mem_wvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .mem_err_i      (mem_err_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_instr(input logic [31:0] addr, input logic [31:0] rd, input logic er);
        mq.push_back('{we: 4'h0, addr: addr, wdata: 32'h0});
        dq.push_back('{rv: 1'b1, wv: 1'b0, er: er, rd: rd});
        rq.push_back('{ir: 1'b1, ird: rd, ie: er, dr: 1'b0, dw: 1'b0, drd: 32'h0, de: 1'b0});
    endtask

    task automatic push_data(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rd, input logic er);
        mq.push_back('{we: we, addr: addr, wdata: wd});
        if (we == 4'h0) begin
            dq.push_back('{rv: 1'b1, wv: 1'b0, er: er, rd: rd});
            rq.push_back('{ir: 1'b0, ird: 32'h0, ie: 1'b0, dr: 1'b1, dw: 1'b0, drd: rd, de: er});
        end else begin
            dq.push_back('{rv: 1'b0, wv: 1'b1, er: er, rd: 32'h0});
            rq.push_back('{ir: 1'b0, ird: 32'h0, ie: 1'b0, dr: 1'b0, dw: 1'b1, drd: 32'h0, de: er});
        end
    endtask

    function automatic rexp_t sample_rsp();
        rexp_t o;
        o.ir  = instr_rvalid_o;
        o.ird = instr_rdata_o;
        o.ie  = instr_err_o;
        o.dr  = data_rvalid_o;
        o.dw  = data_wvalid_o;
        o.drd = data_rdata_o;
        o.de  = data_err_o;
        return o;
    endfunction

    // Wait (bounded) for the mem_req_o pulse and compare the issued request.
    task automatic wait_issue(output bit ok, output int cyc);
        mexp_t e, o;
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < 10) begin
            @(negedge clk);
            #1;
            cyc++;
            if (mem_req_o === 1'b1) ok = 1'b1;
        end
        if (!ok) chk("issue_seen", 128'(mem_req_o), 128'(1'b1));
        if (mq.size() == 0) begin
            chk("sb_mem_empty", 128'(mq.size()), 128'(1));
        end else begin
            e = mq.pop_front();
            if (ok) begin
                o.we    = mem_we_o;
                o.addr  = mem_addr_o;
                o.wdata = mem_wdata_o;
                chk("mem_side", 128'(o), 128'(e));
            end
        end
    endtask

    task automatic respond(input int delay, input bit ok);
        drv_t  d;
        rexp_t e;
        if (dq.size() == 0 || rq.size() == 0) begin
            chk("sb_rsp_empty", 128'(rq.size()), 128'(1));
            return;
        end
        d = dq.pop_front();
        e = rq.pop_front();
        if (!ok) return;
        repeat (delay + 1) @(negedge clk);
        mem_rvalid_i = d.rv;
        mem_wvalid_i = d.wv;
        mem_err_i    = d.er;
        mem_rdata_i  = d.rd;
        #1;
        chk("req_pulse", 128'(mem_req_o), 128'(1'b0));
        chk("rsp", 128'(sample_rsp()), 128'(e));
        @(posedge clk);
        #1;
        mem_rvalid_i = 1'b0;
        mem_wvalid_i = 1'b0;
        mem_err_i    = 1'b0;
        mem_rdata_i  = 32'h0;
    endtask

    task automatic serve(input int delay);
        bit ok;
        int cyc;
        wait_issue(ok, cyc);
        respond(delay, ok);
    endtask

    initial begin
        bit    ok;
        bit    early;
        int    cyc;
        rst          = 1'b1;
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h0;
        data_req_i   = 1'b0;
        data_we_i    = 4'h0;
        data_addr_i  = 32'h0;
        data_wdata_i = 32'h0;
        mem_rvalid_i = 1'b0;
        mem_wvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        mem_err_i    = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_mem", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}, 128'h0);
        chk("reset_rsp", 128'(sample_rsp()), 128'h0);
        @(negedge clk);
        rst = 1'b0;

        // Tie right after reset: instr first, then data; instr re-requests at once.
        @(negedge clk);
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h40;
        data_req_i   = 1'b1;
        data_we_i    = 4'hF;
        data_addr_i  = 32'h80;
        data_wdata_i = 32'hCAFEF00D;
        push_instr(32'h40, 32'h11111111, 1'b0);
        push_data(4'hF, 32'h80, 32'hCAFEF00D, 32'h0, 1'b0);
        serve(0);
        instr_addr_i = 32'h44;
        push_instr(32'h44, 32'h33333333, 1'b0);
        serve(1);
        data_req_i = 1'b0;
        data_we_i  = 4'h0;
        serve(2);
        instr_req_i = 1'b0;

        // Instr-only read: mem_req_o one cycle after the request, response next cycle.
        @(negedge clk);
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h100;
        push_instr(32'h100, 32'hDEADBEEF, 1'b0);
        wait_issue(ok, cyc);
        chk("issue_latency", 128'(cyc), 128'(1));
        respond(0, ok);
        instr_req_i = 1'b0;

        // Partial byte write.
        @(negedge clk);
        data_req_i   = 1'b1;
        data_we_i    = 4'b0011;
        data_addr_i  = 32'h200;
        data_wdata_i = 32'h1234;
        push_data(4'b0011, 32'h200, 32'h1234, 32'h0, 1'b0);
        serve(0);
        data_req_i = 1'b0;
        data_we_i  = 4'h0;

        // Timeout: err on the 16th WAIT cycle only, then a late response is dropped.
        @(negedge clk);
        data_req_i   = 1'b1;
        data_addr_i  = 32'h300;
        data_wdata_i = 32'h0;
        mq.push_back('{we: 4'h0, addr: 32'h300, wdata: 32'h0});
        wait_issue(ok, cyc);
        early = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            #1;
            if (i < 15) begin
                early = early | data_err_o | instr_err_o | data_rvalid_o;
            end else begin
                chk("tmo_err", {instr_err_o, data_err_o, data_rvalid_o}, 128'b010);
            end
        end
        chk("tmo_early", 128'(early), 128'(1'b0));
        @(posedge clk);
        #1;
        data_req_i = 1'b0;
        @(negedge clk);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0BAD0;
        #1;
        chk("late_drop", {mem_req_o, 69'(sample_rsp())}, 128'h0);
        @(posedge clk);
        #1;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;

        // Error together with read data on an instr fetch.
        @(negedge clk);
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h500;
        push_instr(32'h500, 32'h00000077, 1'b1);
        serve(0);
        instr_req_i = 1'b0;

        // Reset while waiting, then a tie must again go to instr.
        @(negedge clk);
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h600;
        mq.push_back('{we: 4'h0, addr: 32'h600, wdata: 32'h0});
        wait_issue(ok, cyc);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_wait", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, instr_rvalid_o, instr_err_o}, 128'h0);
        instr_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h700;
        data_req_i   = 1'b1;
        data_we_i    = 4'h0;
        data_addr_i  = 32'h704;
        push_instr(32'h700, 32'hA5A5A5A5, 1'b0);
        push_data(4'h0, 32'h704, 32'h0, 32'h5A5A5A5A, 1'b0);
        serve(0);
        instr_req_i = 1'b0;
        serve(3);
        data_req_i = 1'b0;

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
